// File: rtl/branch_unit_if.sv
// Signal bundle for the branch resolver: decode-side request, fetch-side response
// and the shared ALU operand/op/status path the resolver drives as initiator.
interface branch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_pc;
    logic [31:0] req_imm;

    logic [31:0] alu_ain;
    logic [31:0] alu_bin;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
    logic [2:0]  alu_status;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_taken;
    logic        resp_illegal;
    logic [31:0] resp_next_pc;

    modport master (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
        output req_ready,
        output alu_ain, alu_bin, alu_op,
        input  alu_out, alu_status,
        output resp_valid, resp_taken, resp_illegal, resp_next_pc,
        input  resp_ready
    );

    modport slave (
        output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm,
        input  req_ready,
        input  alu_ain, alu_bin, alu_op,
        output alu_out, alu_status,
        input  resp_valid, resp_taken, resp_illegal, resp_next_pc,
        output resp_ready
    );
endinterface

// File: rtl/branch_unit.sv
// Multi-cycle conditional branch resolver: compares through the ALU with a SUB,
// forms the taken target with an ADD, and hands the next PC to fetch.
`ifndef ADD
`define ADD 3'b000
`endif

module branch_unit (
    input  logic          clk,
    input  logic          rst,
    branch_unit_if.master bus
);
    localparam logic [2:0]  ALU_SUB  = 3'b110;
    localparam logic [2:0]  ALU_ADD  = `ADD;
    localparam logic [31:0] SIGN_BIT = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, CMP, TGT, DONE} state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [31:0] pc;
        logic [31:0] imm;
    } br_req_t;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic        illegal;
        logic [31:0] next_pc;
    } br_resp_t;

    state_t      state, state_n;
    br_req_t     req_q, req_n;
    br_resp_t    resp_q, resp_n;
    logic [31:0] ain_q, ain_n, bin_q, bin_n;
    logic [2:0]  op_q, op_n;

    logic eq, lt, cond, illegal, unsigned_cmp;

    assign eq = bus.alu_status[0];
    assign lt = bus.alu_status[2] ^ bus.alu_status[1];

    // Condition is evaluated against the latched funct3, since the request bus may move after acceptance.
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (req_q.funct3)
            3'b000:          cond = eq;
            3'b001:          cond = !eq;
            3'b100, 3'b110:  cond = lt;
            3'b101, 3'b111:  cond = !lt;
            default:         illegal = 1'b1;
        endcase
    end

    // Unsigned compares reuse the signed ALU path by flipping both sign bits.
    assign unsigned_cmp = bus.req_funct3[2] & bus.req_funct3[1];

    always_comb begin
        state_n = state;
        req_n   = req_q;
        resp_n  = resp_q;
        ain_n   = ain_q;
        bin_n   = bin_q;
        op_n    = op_q;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    req_n.funct3 = bus.req_funct3;
                    req_n.pc     = bus.req_pc;
                    req_n.imm    = bus.req_imm;
                    ain_n        = unsigned_cmp ? (bus.req_rs1 ^ SIGN_BIT) : bus.req_rs1;
                    bin_n        = unsigned_cmp ? (bus.req_rs2 ^ SIGN_BIT) : bus.req_rs2;
                    op_n         = ALU_SUB;
                    state_n      = CMP;
                end
            end
            CMP: begin
                resp_n.illegal = illegal;
                resp_n.taken   = cond && !illegal;
                if (cond && !illegal) begin
                    ain_n   = req_q.pc;
                    bin_n   = req_q.imm;
                    op_n    = ALU_ADD;
                    state_n = TGT;
                end else begin
                    resp_n.next_pc = req_q.pc + 32'd4;
                    resp_n.valid   = 1'b1;
                    state_n        = DONE;
                end
            end
            TGT: begin
                resp_n.next_pc = bus.alu_out;
                resp_n.valid   = 1'b1;
                state_n        = DONE;
            end
            DONE: begin
                if (bus.resp_ready) begin
                    resp_n.valid = 1'b0;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            req_q  <= '0;
            resp_q <= '0;
            ain_q  <= '0;
            bin_q  <= '0;
            op_q   <= 3'b000;
        end else begin
            state  <= state_n;
            req_q  <= req_n;
            resp_q <= resp_n;
            ain_q  <= ain_n;
            bin_q  <= bin_n;
            op_q   <= op_n;
        end
    end

    assign bus.req_ready    = (state == IDLE) && !rst;
    assign bus.alu_ain      = ain_q;
    assign bus.alu_bin      = bin_q;
    assign bus.alu_op       = op_q;
    assign bus.resp_valid   = resp_q.valid;
    assign bus.resp_taken   = resp_q.taken;
    assign bus.resp_illegal = resp_q.illegal;
    assign bus.resp_next_pc = resp_q.next_pc;
endmodule
